// File: rtl/regime_arbiter.sv
// Round-robin arbiter sharing the clock-mode control path between requesters A and B.
// Drives on/start for the granted side; a launch watchdog frees the grant on no acceptance.
module regime_arbiter #(
  parameter int LAUNCH_MAX = 15,
  parameter int TW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [1:0] mode_a,
  input  logic       start_a,
  input  logic       req_b,
  input  logic [1:0] mode_b,
  input  logic       start_b,
  input  logic [1:0] cp_regime,
  input  logic       cp_active,
  output logic [1:0] on,
  output logic       start,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t          r_state;
  logic            r_ptr;      // 0: A has priority on a tie, 1: B
  logic            r_owner;    // 0: A granted, 1: B granted
  logic [TW-1:0]   r_wd;
  logic [1:0]      r_mode_q;
  logic [1:0]      r_on;
  logic            r_start;
  logic            r_gnt_a;
  logic            r_gnt_b;
  logic            r_busy;
  logic            r_timeout;

  logic            w_va;
  logic            w_vb;
  logic            w_pick_b;
  logic            w_own_req;
  logic            w_own_start;
  logic            w_unused;

  localparam logic [TW-1:0] WD_LAST = TW'(LAUNCH_MAX - 1);

  assign w_va        = req_a & (mode_a != 2'd0);
  assign w_vb        = req_b & (mode_b != 2'd0);
  assign w_pick_b    = w_vb & (~w_va | r_ptr);
  assign w_own_req   = r_owner ? req_b : req_a;
  assign w_own_start = r_owner ? start_b : start_a;
  assign w_unused    = cp_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_wd      <= '0;
      r_mode_q  <= '0;
      r_on      <= '0;
      r_start   <= 1'b0;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_on    <= '0;
          r_start <= 1'b0;
          r_gnt_a <= 1'b0;
          r_gnt_b <= 1'b0;
          r_busy  <= 1'b0;
          if (w_va || w_vb) begin
            r_owner  <= w_pick_b;
            r_mode_q <= w_pick_b ? mode_b : mode_a;
            r_on     <= w_pick_b ? mode_b : mode_a;
            r_gnt_a  <= ~w_pick_b;
            r_gnt_b  <= w_pick_b;
            r_wd     <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wd <= r_wd + 1'b1;
          if (cp_regime == r_mode_q) begin
            r_on    <= '0;
            r_state <= S_RUN;
          end else if (r_wd == WD_LAST) begin
            r_on      <= '0;
            r_timeout <= 1'b1;
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_state   <= S_RELEASE;
          end
        end
        S_RUN: begin
          if (cp_regime == 2'd0) begin
            r_start <= 1'b0;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_state <= S_RELEASE;
          end else begin
            // A dropped request masks start while the grant is kept until completion.
            r_start <= w_own_req & w_own_start;
          end
        end
        S_RELEASE: begin
          r_ptr   <= ~r_owner;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign on      = r_on;
  assign start   = r_start;
  assign gnt_a   = r_gnt_a;
  assign gnt_b   = r_gnt_b;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_regime_arbiter.sv
// Scoreboard bench for regime_arbiter: expected output vectors are queued as stimulus
// is applied and popped/compared one cycle later, after the clock edge.
module tb_regime_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, start_a, req_b, start_b, cp_active;
  logic [1:0] mode_a, mode_b, cp_regime;
  logic [1:0] on;
  logic       start, gnt_a, gnt_b, busy, timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [6:0]  sb_q[$];

  regime_arbiter #(.LAUNCH_MAX(15), .TW(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .mode_a(mode_a), .start_a(start_a),
    .req_b(req_b), .mode_b(mode_b), .start_b(start_b),
    .cp_regime(cp_regime), .cp_active(cp_active),
    .on(on), .start(start), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // {on[1:0], start, gnt_a, gnt_b, busy, timeout}
  function automatic logic [6:0] ov(input logic [1:0] o, input logic s, input logic ga,
                                    input logic gb, input logic bz, input logic to);
    return {o, s, ga, gb, bz, to};
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got on=%0d start=%b ga=%b gb=%b busy=%b to=%b, exp on=%0d start=%b ga=%b gb=%b busy=%b to=%b",
               tag, got[6:5], got[4], got[3], got[2], got[1], got[0],
               exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Push expectation for the coming edge, advance one cycle, pop and compare.
  task automatic cyc(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(tag, {on, start, gnt_a, gnt_b, busy, timeout}, e);
  endtask

  localparam logic [6:0] ZERO = 7'b0;

  initial begin
    rst = 1'b1; req_a = 0; mode_a = 0; start_a = 0;
    req_b = 0; mode_b = 0; start_b = 0; cp_regime = 0; cp_active = 0;
    #2;

    // Reset then single grant
    cyc("reset0", ZERO);
    cyc("reset1", ZERO);
    rst = 1'b0;
    req_a = 1; mode_a = 2;
    cyc("grant_a", ov(2, 0, 1, 0, 1, 0));
    cyc("launch_hold", ov(2, 0, 1, 0, 1, 0));
    cp_regime = 2;
    cyc("enter_run", ov(0, 0, 1, 0, 1, 0));
    start_a = 1; req_b = 1; mode_b = 3;
    cyc("start_fwd", ov(0, 1, 1, 0, 1, 0));
    cyc("start_hold", ov(0, 1, 1, 0, 1, 0));
    req_a = 0;
    cyc("req_drop", ov(0, 0, 1, 0, 1, 0));
    req_a = 1;
    cyc("req_back", ov(0, 1, 1, 0, 1, 0));
    start_a = 0;
    cyc("start_low", ov(0, 0, 1, 0, 1, 0));
    cp_regime = 0; req_a = 0;
    cyc("run_done", ov(0, 0, 0, 0, 1, 0));
    cyc("release_idle", ZERO);
    cyc("grant_b", ov(3, 0, 0, 1, 1, 0));
    cp_regime = 3;
    cyc("b_run", ov(0, 0, 0, 1, 1, 0));
    cp_regime = 0;
    cyc("b_done", ov(0, 0, 0, 0, 1, 0));
    req_b = 0;
    cyc("b_idle", ZERO);

    // Simultaneous requests alternate, A first after reset
    rst = 1'b1;
    cyc("reset2", ZERO);
    rst = 1'b0;
    req_a = 1; mode_a = 1; req_b = 1; mode_b = 2;
    for (int i = 0; i < 4; i++) begin
      logic       wb;
      logic [1:0] m;
      wb = (i % 2) == 1;
      m  = wb ? 2'd2 : 2'd1;
      cyc($sformatf("rr_grant%0d", i), ov(m, 0, ~wb, wb, 1, 0));
      cp_regime = m;
      cyc($sformatf("rr_run%0d", i), ov(0, 0, ~wb, wb, 1, 0));
      cp_regime = 0;
      cyc($sformatf("rr_rel%0d", i), ov(0, 0, 0, 0, 1, 0));
      cyc($sformatf("rr_idle%0d", i), ZERO);
    end
    req_a = 0; req_b = 0;
    cyc("rr_quiet", ZERO);

    // Watchdog: on held 15 cycles then one-cycle timeout
    req_a = 1; mode_a = 1; cp_regime = 0;
    cyc("wd_grant", ov(1, 0, 1, 0, 1, 0));
    for (int i = 0; i < 14; i++)
      cyc($sformatf("wd_on%0d", i), ov(1, 0, 1, 0, 1, 0));
    cyc("wd_timeout", ov(0, 0, 0, 0, 1, 1));
    req_b = 1; mode_b = 2;
    cyc("wd_release", ZERO);
    cyc("wd_ptr_b", ov(2, 0, 0, 1, 1, 0));
    rst = 1'b1;
    cyc("reset_launch", ZERO);
    rst = 1'b0; req_a = 0;

    // Invalid request ignored
    req_b = 1; mode_b = 0;
    cyc("invalid0", ZERO);
    cyc("invalid1", ZERO);
    req_b = 0;

    // Mid-run reset, then tie goes to A
    req_a = 1; mode_a = 3;
    cyc("mr_grant", ov(3, 0, 1, 0, 1, 0));
    cp_regime = 3;
    cyc("mr_run", ov(0, 0, 1, 0, 1, 0));
    start_a = 1;
    cyc("mr_start", ov(0, 1, 1, 0, 1, 0));
    rst = 1'b1;
    cyc("mr_reset", ZERO);
    rst = 1'b0; cp_regime = 0; start_a = 0;
    req_b = 1; mode_b = 2;
    cyc("mr_tie_a", ov(3, 0, 1, 0, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
